// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: SHOW/GAP sequencing, per-frame digit snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (3..1) during SHOW.
//
// state  | meaning
// S_IDLE | display off, index held at 0, waiting for enable
// S_SHOW | current digit lit for PRESCALE cycles
// S_GAP  | all off for GAP_CYCLES cycles, index already advanced
module seg7_scan_ctrl #(
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  output logic [1:0]  dig_sel,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic        blank,
  output logic        frame_done
);

  localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? ((PRESCALE > 2) ? PRESCALE : 2)
                                                   : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [15:0]     sh_dig;
  logic [3:0]      sh_dp;
  logic            load_sh;
  logic            cnt_tc;
  logic            lz_blank;

  assign cnt_tc = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= 2'd0;
      cnt    <= '0;
      sh_dig <= 16'h0000;
      sh_dp  <= 4'h0;
    end else begin
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      if (load_sh) begin
        sh_dig <= digits;
        sh_dp  <= dp_mask;
      end
    end
  end

  // Shadow reloads only when a frame (digit 0 SHOW) is about to begin.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    load_sh   = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_SHOW;
          idx_nxt   = 2'd0;
          cnt_nxt   = SHOW_LOAD;
          load_sh   = 1'b1;
        end
        S_SHOW: begin
          if (cnt_tc) begin
            idx_nxt = idx + 2'd1;
            if (HAS_GAP) begin
              state_nxt = S_GAP;
              cnt_nxt   = GAP_LOAD;
            end else begin
              state_nxt = S_SHOW;
              cnt_nxt   = SHOW_LOAD;
              load_sh   = (idx == 2'd3);
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_tc) begin
            state_nxt = S_SHOW;
            cnt_nxt   = SHOW_LOAD;
            load_sh   = (idx == 2'd0);
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx)
      2'd3:    lz_blank = (sh_dig[15:12] == 4'h0)  && !sh_dp[3];
      2'd2:    lz_blank = (sh_dig[15:8]  == 8'h00) && !sh_dp[2];
      2'd1:    lz_blank = (sh_dig[15:4]  == 12'h000) && !sh_dp[1];
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    dig_sel    = idx;
    bcd_out    = 4'h0;
    dp_out     = 1'b0;
    blank      = 1'b1;
    frame_done = 1'b0;
    case (state)
      S_SHOW: begin
        bcd_out    = sh_dig[{idx, 2'b00} +: 4];
        dp_out     = sh_dp[idx];
        blank      = lz_blank;
        frame_done = cnt_tc && (idx == 2'd3);
      end
      S_GAP: begin
        bcd_out = sh_dig[{idx, 2'b00} +: 4];
        dp_out  = sh_dp[idx];
      end
      default: ;
    endcase
  end

endmodule
